mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_rr2.sv | 24 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

    localparam int LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_RESP   = 3'd2,
        ST_DUMP   = 3'd3,
        ST_HALTED = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Wait-counter load value for a given access latency.
    function automatic logic [1:0] cnt_load(input int lat);
        return 2'(lat - 1);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: bit 0 = fetch, bit 1 = data.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] grant
);

    // A lone requester wins outright; a tie goes to the port not served last.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (last == OWN_FETCH) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Each transaction holds the memory for LATENCY cycles, then pulses done.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    input  logic        halt,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_dump
);

    localparam logic [1:0] CNT_LOAD = cnt_load(LATENCY);

    arb_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    owner_t      last_q, last_d;
    owner_t      owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] i_rdata_q, i_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_dump_q, mem_dump_d;
    logic [1:0]  grant_s;
    logic [15:0] cap_s;

    arb_rr2 u_rr (
        .req   ({d_req, i_req}),
        .last  (last_q),
        .grant (grant_s)
    );

    // Next-state and next-output logic; outputs are registered from the _d values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        mem_en_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_dump_d = 1'b0;
        cap_s      = wr_q ? 16'h0000 : mem_rdata;
        case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d    = ST_DUMP;
                    mem_dump_d = 1'b1;
                end else if (grant_s != 2'b00) begin
                    owner_d  = grant_s[1] ? OWN_DATA : OWN_FETCH;
                    last_d   = owner_d;
                    addr_d   = grant_s[1] ? d_addr : i_addr;
                    wr_d     = grant_s[1] & d_wr;
                    wdata_d  = grant_s[1] ? d_wdata : 16'h0000;
                    cnt_d    = CNT_LOAD;
                    mem_en_d = 1'b1;
                    mem_wr_d = wr_d;
                    state_d  = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 2'd0) begin
                    // Last access cycle: memory data is valid now, capture it.
                    state_d = ST_RESP;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = cap_s;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = cap_s;
                        i_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q - 2'd1;
                    mem_en_d = 1'b1;
                    mem_wr_d = wr_q;
                end
            end
            ST_RESP:   state_d = ST_IDLE;
            ST_DUMP:   state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= OWN_FETCH;
            owner_q    <= OWN_FETCH;
            wr_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            i_rdata_q  <= 16'h0000;
            d_rdata_q  <= 16'h0000;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_dump_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_dump_q <= mem_dump_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign i_stall   = i_req & ~i_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_stall   = d_req & ~d_done_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_dump  = mem_dump_q;

endmodule
